demux_router: RTL

- Registered 1-to-2 demultiplexer that steers WIDTH-bit words from one input stream to output 0 or 1, selected by sel.
- Each output has a single-entry holding slot and a valid/ready handshake.
- Sits downstream of the team's 2:1 mux path and is the return/fan-out direction: one source, two sinks.
- Zero output when a slot is empty, matching the team's "disabled means 4'b0000" convention.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_slot.sv | 73 +++++++
 rtl/demux_router.sv | 79 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 registered demultiplexer.
// Slot FSM state encoding and the value a sink sees from an empty slot.
package demux_pkg;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    // What Y0/Y1 show while their slot is empty.
    localparam int DEMUX_ZERO = 0;

endpackage

// File: rtl/demux_slot.sv
// Single-entry holding slot with valid/ready output handshake.
// Ports: clk, rst (sync, active-high), load/din (fill), yready (sink),
//        y/yvalid (slot output), cnt (drain counter, DEMUX_CNT_EN only).
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             yready,
    output logic [WIDTH-1:0] y,
    output logic             yvalid
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_e state;
    logic        drain;

    assign drain = (state == SLOT_FULL) && yready;

    // y is cleared on drain so the held word is never visible once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SLOT_EMPTY;
            y      <= WIDTH'(DEMUX_ZERO);
            yvalid <= 1'b0;
        end else begin
            unique case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state  <= SLOT_FULL;
                        y      <= din;
                        yvalid <= 1'b1;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        y      <= din;
                        yvalid <= 1'b1;
                    end else if (drain) begin
                        state  <= SLOT_EMPTY;
                        y      <= WIDTH'(DEMUX_ZERO);
                        yvalid <= 1'b0;
                    end
                end
                default: begin
                    state  <= SLOT_EMPTY;
                    y      <= WIDTH'(DEMUX_ZERO);
                    yvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    // Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-2 demux: steers D to slot 0 or 1 by sel, 1-cycle latency.
// Ports: clk, rst, en, sel, D, in_valid, in_ready, Y0/Y0_valid/Y0_ready,
//        Y1/Y1_valid/Y1_ready, cnt0/cnt1 (only when DEMUX_CNT_EN is defined).
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] D,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_valid,
    input  logic             Y0_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_valid,
    input  logic             Y1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic room0;
    logic room1;
    logic accept;
    logic load0;
    logic load1;

    // A full slot still has room if its sink drains it this cycle.
    assign room0 = !Y0_valid || Y0_ready;
    assign room1 = !Y1_valid || Y1_ready;

    assign in_ready = en && !rst && (sel ? room1 : room0);
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !sel;
    assign load1    = accept && sel;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk    (clk),
        .rst    (rst),
        .load   (load0),
        .din    (D),
        .yready (Y0_ready),
        .y      (Y0),
        .yvalid (Y0_valid)
`ifdef DEMUX_CNT_EN
        ,
        .cnt    (cnt0)
`endif
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk    (clk),
        .rst    (rst),
        .load   (load1),
        .din    (D),
        .yready (Y1_ready),
        .y      (Y1),
        .yvalid (Y1_valid)
`ifdef DEMUX_CNT_EN
        ,
        .cnt    (cnt1)
`endif
    );

endmodule
